// File: rtl/ips2l_clk_gen_frac_mc.sv
// ips2l_clk_gen_frac_mc: multi-channel fractional clock-enable generator with glitch-free divisor reload.
// Rev 1.0 - initial release.
`default_nettype none

module ips2l_clk_gen_frac_mc #(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4,
    parameter int OVS    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [NUM_CH*DIV_W-1:0]  div_int,
    input  logic [NUM_CH*FRAC_W-1:0] div_frac,
    input  logic [NUM_CH-1:0]        div_load,
    input  logic [NUM_CH-1:0]        phase_clr,
    output logic [NUM_CH-1:0]        div_ack,
    output logic [NUM_CH-1:0]        clk_en_ovs,
    output logic [NUM_CH-1:0]        clk_en
);

    localparam int              OVS_W    = (OVS > 1) ? $clog2(OVS) : 1;
    localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);
    localparam logic [0:0]      S_IDLE   = 1'b0;
    localparam logic [0:0]      S_RUN    = 1'b1;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [0:0]        state;
            logic [DIV_W-1:0]  cnt;
            logic [FRAC_W-1:0] acc;
            logic [OVS_W-1:0]  ovs_cnt;
            logic              pend;
            logic [DIV_W-1:0]  int_a;
            logic [DIV_W-1:0]  int_s;
            logic [FRAC_W-1:0] frac_a;
            logic [FRAC_W-1:0] frac_s;
            logic              ovs_q;
            logic              en_q;
            logic              ack_q;

            logic [DIV_W-1:0]  bus_int;
            logic [FRAC_W-1:0] bus_frac;
            logic [FRAC_W:0]   sum;
            logic [DIV_W:0]    eff;
            logic [DIV_W:0]    last;
            logic              wrap;
            logic              apply;

            // last = P-1, computed one bit wider so div_int = 2^DIV_W-1 plus carry still fits
            always_comb begin
                bus_int  = div_int[i*DIV_W +: DIV_W];
                bus_frac = div_frac[i*FRAC_W +: FRAC_W];
                sum      = {1'b0, acc} + {1'b0, frac_a};
                eff      = (int_a == '0) ? {{DIV_W{1'b0}}, 1'b1} : {1'b0, int_a};
                last     = eff + {{DIV_W{1'b0}}, sum[FRAC_W]} - {{DIV_W{1'b0}}, 1'b1};
                wrap     = (state == S_RUN) && ch_en[i] && ({1'b0, cnt} == last);
                apply    = pend && ((state == S_IDLE) || wrap || phase_clr[i]);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state   <= S_IDLE;
                    cnt     <= '0;
                    acc     <= '0;
                    ovs_cnt <= '0;
                    pend    <= 1'b0;
                    int_a   <= DIV_W'(1);
                    frac_a  <= '0;
                    int_s   <= DIV_W'(1);
                    frac_s  <= '0;
                    ovs_q   <= 1'b0;
                    en_q    <= 1'b0;
                    ack_q   <= 1'b0;
                end else begin
                    ovs_q <= 1'b0;
                    en_q  <= 1'b0;
                    ack_q <= 1'b0;

                    if (state == S_IDLE) begin
                        cnt     <= '0;
                        acc     <= '0;
                        ovs_cnt <= '0;
                        if (ch_en[i]) begin
                            state <= S_RUN;
                        end
                    end else if (!ch_en[i] || phase_clr[i]) begin
                        // Stop or phase restart: suppress any tick coinciding with this edge
                        cnt     <= '0;
                        acc     <= '0;
                        ovs_cnt <= '0;
                        if (!ch_en[i]) begin
                            state <= S_IDLE;
                        end
                    end else if (wrap) begin
                        cnt   <= '0;
                        acc   <= sum[FRAC_W-1:0];
                        ovs_q <= 1'b1;
                        if (ovs_cnt == OVS_LAST) begin
                            ovs_cnt <= '0;
                            en_q    <= 1'b1;
                        end else begin
                            ovs_cnt <= ovs_cnt + OVS_W'(1);
                        end
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end

                    if (div_load[i]) begin
                        int_s  <= bus_int;
                        frac_s <= bus_frac;
                    end

                    // A load arriving on the apply edge bypasses the shadow so only one ack is seen
                    if (apply) begin
                        int_a  <= div_load[i] ? bus_int  : int_s;
                        frac_a <= div_load[i] ? bus_frac : frac_s;
                        pend   <= 1'b0;
                        cnt    <= '0;
                        acc    <= '0;
                        ack_q  <= 1'b1;
                    end else if (div_load[i]) begin
                        pend <= 1'b1;
                    end
                end
            end

            assign clk_en_ovs[i] = ovs_q;
            assign clk_en[i]     = en_q;
            assign div_ack[i]    = ack_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_ips2l_clk_gen_frac_mc.sv
// tb_ips2l_clk_gen_frac_mc: directed self-checking bench for the fractional clock-enable generator.
// Rev 1.0 - initial release.
`default_nettype none
`timescale 1ns/1ps

module tb_ips2l_clk_gen_frac_mc;

    localparam int NUM_CH = 2;
    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OVS    = 16;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH-1:0]        ch_en;
    logic [NUM_CH*DIV_W-1:0]  div_int;
    logic [NUM_CH*FRAC_W-1:0] div_frac;
    logic [NUM_CH-1:0]        div_load;
    logic [NUM_CH-1:0]        phase_clr;
    logic [NUM_CH-1:0]        div_ack;
    logic [NUM_CH-1:0]        clk_en_ovs;
    logic [NUM_CH-1:0]        clk_en;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ips2l_clk_gen_frac_mc #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS)
    ) dut (
        .clk(clk), .rst(rst), .ch_en(ch_en), .div_int(div_int), .div_frac(div_frac),
        .div_load(div_load), .phase_clr(phase_clr), .div_ack(div_ack),
        .clk_en_ovs(clk_en_ovs), .clk_en(clk_en)
    );

    // Two-negedge load pulse; the apply happens on the following edge when the channel is idle
    task automatic load(input int ch, input int vi, input int vf);
        @(negedge clk);
        div_int[ch*DIV_W +: DIV_W]    = vi[DIV_W-1:0];
        div_frac[ch*FRAC_W +: FRAC_W] = vf[FRAC_W-1:0];
        div_load[ch] = 1'b1;
        @(negedge clk);
        div_load[ch] = 1'b0;
    endtask

    task automatic wait_ovs(input int ch, input int lim, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!clk_en_ovs[ch] && k < lim);
        if (!clk_en_ovs[ch]) k = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ch_en = '0; div_int = '0; div_frac = '0; div_load = '0; phase_clr = '0;
        repeat (3) @(negedge clk);
        tests++; if (clk_en_ovs !== 2'b00) begin fails++; $display("FAIL reset_ovs got=%b exp=00", clk_en_ovs); end
        tests++; if (clk_en !== 2'b00) begin fails++; $display("FAIL reset_en got=%b exp=00", clk_en); end
        tests++; if (div_ack !== 2'b00) begin fails++; $display("FAIL reset_ack got=%b exp=00", div_ack); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int k, bad_sp, bad_en;
        load(0, 4, 0);
        @(negedge clk);
        tests++; if (div_ack[0] !== 1'b1) begin fails++; $display("FAIL idle_ack got=%b exp=1", div_ack[0]); end
        ch_en[0] = 1'b1;
        wait_ovs(0, 20, k);
        tests++; if (k !== 5) begin fails++; $display("FAIL basic_first got=%0d exp=5", k); end
        bad_sp = 0; bad_en = 0;
        for (int j = 2; j <= 16; j++) begin
            wait_ovs(0, 10, k);
            if (k !== 4) bad_sp++;
            if (j < 16 && clk_en[0] !== 1'b0) bad_en++;
        end
        tests++; if (bad_sp !== 0) begin fails++; $display("FAIL basic_spacing bad=%0d exp=0", bad_sp); end
        tests++; if (bad_en !== 0 || clk_en[0] !== 1'b1) begin fails++; $display("FAIL basic_en16 early=%0d en=%b exp=0,1", bad_en, clk_en[0]); end
        k = 0;
        do begin @(negedge clk); k++; end while (!clk_en[0] && k < 100);
        tests++; if (k !== 64) begin fails++; $display("FAIL basic_en_period got=%0d exp=64", k); end
    endtask

    task automatic test_frac();
        int k, k2, k3, t, t16, t32, n_en, bad;
        @(negedge clk); ch_en[0] = 1'b0;
        load(0, 4, 8);
        @(negedge clk); ch_en[0] = 1'b1;
        wait_ovs(0, 20, k);
        tests++; if (k !== 5) begin fails++; $display("FAIL frac_first got=%0d exp=5", k); end
        t = 0; t16 = 0; t32 = 0; n_en = 0; k2 = 0; k3 = 0; bad = 0;
        for (int j = 2; j <= 33; j++) begin
            wait_ovs(0, 10, k);
            if (k < 0) bad++;
            t += k;
            if (j == 2) k2 = k;
            if (j == 3) k3 = k;
            if (clk_en[0]) begin
                n_en++;
                if (j == 16) t16 = t;
                if (j == 32) t32 = t;
            end
        end
        tests++; if (k2 !== 5 || k3 !== 4) begin fails++; $display("FAIL frac_pattern got=%0d,%0d exp=5,4", k2, k3); end
        tests++; if (t !== 144 || bad !== 0) begin fails++; $display("FAIL frac_total got=%0d exp=144", t); end
        tests++; if (n_en !== 2) begin fails++; $display("FAIL frac_en_count got=%0d exp=2", n_en); end
        tests++; if (t32 - t16 !== 72) begin fails++; $display("FAIL frac_en_spacing got=%0d exp=72", t32 - t16); end
    endtask

    task automatic test_continuous();
        int lows;
        for (int v = 0; v <= 1; v++) begin
            @(negedge clk); ch_en[0] = 1'b0;
            load(0, v, 0);
            @(negedge clk); ch_en[0] = 1'b1;
            @(negedge clk);
            lows = 0;
            repeat (10) begin
                @(negedge clk);
                if (clk_en_ovs[0] !== 1'b1) lows++;
            end
            tests++; if (lows !== 0) begin fails++; $display("FAIL cont_div%0d low_cycles=%0d exp=0", v, lows); end
            ch_en[0] = 1'b0;
            @(negedge clk);
            tests++; if (clk_en_ovs[0] !== 1'b0) begin fails++; $display("FAIL cont_off_div%0d got=%b exp=0", v, clk_en_ovs[0]); end
        end
    endtask

    task automatic test_reload();
        int k, acks, ticks;
        @(negedge clk); ch_en[0] = 1'b0;
        load(0, 10, 0);
        @(negedge clk); ch_en[0] = 1'b1;
        wait_ovs(0, 20, k);
        repeat (2) @(negedge clk);
        div_int[0 +: DIV_W] = 16'd3; div_load[0] = 1'b1;
        @(negedge clk); div_load[0] = 1'b0;
        wait_ovs(0, 20, k);
        tests++; if (k + 3 !== 10) begin fails++; $display("FAIL reload_hold got=%0d exp=10", k + 3); end
        tests++; if (div_ack[0] !== 1'b1) begin fails++; $display("FAIL reload_ack got=%b exp=1", div_ack[0]); end
        wait_ovs(0, 20, k);
        tests++; if (k !== 3 || div_ack[0] !== 1'b0) begin fails++; $display("FAIL reload_new_period got=%0d ack=%b exp=3,0", k, div_ack[0]); end
        div_int[0 +: DIV_W] = 16'd8; div_load[0] = 1'b1;
        @(negedge clk); div_int[0 +: DIV_W] = 16'd5;
        @(negedge clk); div_load[0] = 1'b0;
        @(negedge clk);
        tests++; if (clk_en_ovs[0] !== 1'b1 || div_ack[0] !== 1'b1) begin fails++; $display("FAIL reload2_apply tick=%b ack=%b exp=1,1", clk_en_ovs[0], div_ack[0]); end
        acks = 0; ticks = 0;
        repeat (20) begin
            @(negedge clk);
            if (div_ack[0]) acks++;
            if (clk_en_ovs[0]) ticks++;
        end
        tests++; if (acks !== 0 || ticks !== 4) begin fails++; $display("FAIL reload2_period acks=%0d ticks=%0d exp=0,4", acks, ticks); end
    endtask

    task automatic test_phase_clr();
        int k, mid, late, last1, bad1, n1, bad_en;
        @(negedge clk); ch_en = 2'b00;
        load(0, 4, 0);
        load(1, 3, 0);
        @(negedge clk); ch_en = 2'b11;
        wait_ovs(0, 20, k);
        mid = 0; late = 0; last1 = -1; bad1 = 0; n1 = 0;
        for (int s = 1; s <= 8; s++) begin
            @(negedge clk);
            phase_clr[0] = (s == 3);
            if (clk_en_ovs[0] && s != 8) mid++;
            if (s == 8 && clk_en_ovs[0]) late = 1;
            if (clk_en_ovs[1]) begin
                if (last1 >= 0 && s - last1 !== 3) bad1++;
                last1 = s; n1++;
            end
        end
        tests++; if (mid !== 0) begin fails++; $display("FAIL phase_no_tick got=%0d exp=0", mid); end
        tests++; if (late !== 1) begin fails++; $display("FAIL phase_next_tick got=%0d exp=1", late); end
        tests++; if (bad1 !== 0 || n1 < 2) begin fails++; $display("FAIL phase_ch1 bad=%0d ticks=%0d exp=0,>=2", bad1, n1); end
        bad_en = 0;
        for (int j = 2; j <= 16; j++) begin
            wait_ovs(0, 10, k);
            if (j < 16 && clk_en[0] !== 1'b0) bad_en++;
        end
        tests++; if (bad_en !== 0 || clk_en[0] !== 1'b1) begin fails++; $display("FAIL phase_ovs_restart early=%0d en=%b exp=0,1", bad_en, clk_en[0]); end
    endtask

    task automatic test_reset_mid();
        int k, acks, lows;
        @(negedge clk); ch_en = 2'b00;
        load(0, 10, 0);
        @(negedge clk); ch_en[0] = 1'b1;
        wait_ovs(0, 20, k);
        repeat (9) @(negedge clk);
        div_int[0 +: DIV_W] = 16'd7; div_load[0] = 1'b1;
        @(negedge clk); div_load[0] = 1'b0;
        tests++; if (clk_en_ovs[0] !== 1'b1) begin fails++; $display("FAIL rstmid_pre_tick got=%b exp=1", clk_en_ovs[0]); end
        #1 rst = 1'b1;
        #1;
        tests++; if ({clk_en_ovs, clk_en, div_ack} !== 6'b0) begin fails++; $display("FAIL rstmid_async got=%b exp=000000", {clk_en_ovs, clk_en, div_ack}); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        acks = 0; lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (div_ack[0]) acks++;
            if (!clk_en_ovs[0]) lows++;
        end
        tests++; if (acks !== 0) begin fails++; $display("FAIL rstmid_no_ack got=%0d exp=0", acks); end
        tests++; if (lows !== 0) begin fails++; $display("FAIL rstmid_default_period low_cycles=%0d exp=0", lows); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frac();
        test_continuous();
        test_reload();
        test_phase_clr();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
